// File: rtl/uart_tx_pkg.sv
// Shared UART TX types and line constants.
// The BREAK state exists only when UART_TX_BREAK_EN is defined.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
`ifdef UART_TX_BREAK_EN
    , BREAK
`endif
  } tx_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Bit-period down-counter shared with the RX side.
// bit_done is high in the last CLK of each bit period; the counter reloads itself there.
module uart_tx_bit_timer #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic CLK,
  input  logic RST,
  input  logic load,
  input  logic en,
  output logic bit_done
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign bit_done = (cnt == '0);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      cnt <= '0;
    else if (load || (en && bit_done))
      cnt <= RELOAD;
    else if (en)
      cnt <= cnt - 1'b1;
  end

endmodule

// File: rtl/uart_tx_frame_gen.sv
// UART transmit frame generator: start, DATA_WIDTH data bits LSB first, optional parity, 1/2 stops.
// Define UART_TX_BREAK_EN to add the BREAK_REQ port and break state.
module uart_tx_frame_gen
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 1,
  parameter int BREAK_BITS   = 11
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
`ifdef UART_TX_BREAK_EN
  input  logic                  BREAK_REQ,
`endif
  output logic                  TX_OUT,
  output logic                  Busy
);

  // One index counter serves data bits, stop bits and break periods.
  localparam int IW = $clog2(((DATA_WIDTH > BREAK_BITS) ? DATA_WIDTH : BREAK_BITS) + 1);

  tx_state_e             state, nxt_state;
  logic [IW-1:0]         idx, nxt_idx;
  logic [DATA_WIDTH-1:0] data_q, data_sh;
  logic                  par_en_q, par_typ_q, stop2_q;
  logic                  accept, load, bit_done, nxt_tx;
`ifdef UART_TX_BREAK_EN
  logic                  brk_pend;
`endif

  assign accept = (state == IDLE) && Data_Valid;

  uart_tx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .CLK      (CLK),
    .RST      (RST),
    .load     (load),
    .en       (state != IDLE),
    .bit_done (bit_done)
  );

  always_comb begin
    nxt_state = state;
    nxt_idx   = idx;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (Data_Valid) begin
          nxt_state = START;
          nxt_idx   = '0;
          load      = 1'b1;
        end
`ifdef UART_TX_BREAK_EN
        else if (BREAK_REQ || brk_pend) begin
          nxt_state = BREAK;
          nxt_idx   = '0;
          load      = 1'b1;
        end
`endif
      end
      START: if (bit_done) begin
        nxt_state = DATA;
        nxt_idx   = '0;
      end
      DATA: if (bit_done) begin
        if (idx == IW'(DATA_WIDTH - 1)) begin
          nxt_state = par_en_q ? PARITY : STOP;
          nxt_idx   = '0;
        end else
          nxt_idx = idx + 1'b1;
      end
      PARITY: if (bit_done) begin
        nxt_state = STOP;
        nxt_idx   = '0;
      end
      STOP: if (bit_done) begin
        if (idx == IW'(stop2_q)) begin
          nxt_state = IDLE;
          nxt_idx   = '0;
        end else
          nxt_idx = idx + 1'b1;
      end
`ifdef UART_TX_BREAK_EN
      BREAK: if (bit_done) begin
        if (idx == IW'(BREAK_BITS - 1)) begin
          nxt_state = IDLE;
          nxt_idx   = '0;
        end else
          nxt_idx = idx + 1'b1;
      end
`endif
      default: begin
        nxt_state = IDLE;
        nxt_idx   = '0;
      end
    endcase

    // Line value is computed for the state being entered so TX_OUT can come straight from a flop.
    data_sh = data_q >> nxt_idx;
    case (nxt_state)
      START:   nxt_tx = START_BIT;
      DATA:    nxt_tx = data_sh[0];
      PARITY:  nxt_tx = (^data_q) ^ par_typ_q;
`ifdef UART_TX_BREAK_EN
      BREAK:   nxt_tx = 1'b0;
`endif
      default: nxt_tx = STOP_BIT;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      idx       <= '0;
      TX_OUT    <= STOP_BIT;
      Busy      <= 1'b0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= PAR_EVEN;
      stop2_q   <= 1'b0;
    end else begin
      state  <= nxt_state;
      idx    <= nxt_idx;
      TX_OUT <= nxt_tx;
      Busy   <= (nxt_state != IDLE);
      if (accept) begin
        data_q    <= P_DATA;
        par_en_q  <= PAR_EN;
        par_typ_q <= PAR_TYP;
        stop2_q   <= STOP2;
      end
    end
  end

`ifdef UART_TX_BREAK_EN
  // A break requested together with a data word is remembered and sent after that frame.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      brk_pend <= 1'b0;
    else if (accept && BREAK_REQ)
      brk_pend <= 1'b1;
    else if (nxt_state == BREAK)
      brk_pend <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_uart_tx_frame_gen.sv
// Randomized bench: three instances (CLKS_PER_BIT 1, 2, 4) share stimulus and are checked
// every cycle against a queue model of the expected line; break cases need UART_TX_BREAK_EN.
module tb_uart_tx_frame_gen;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] pd = '0;
  logic       dv = 1'b0, pe = 1'b0, pt = 1'b0, s2 = 1'b0, breq = 1'b0;
  logic [2:0] tx, busy;

  int n_chk = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    uart_tx_frame_gen #(.DATA_WIDTH(8), .CLKS_PER_BIT(1 << g), .BREAK_BITS(11)) u_dut (
      .CLK        (CLK),
      .RST        (RST),
      .P_DATA     (pd),
      .Data_Valid (dv),
      .PAR_EN     (pe),
      .PAR_TYP    (pt),
      .STOP2      (s2),
`ifdef UART_TX_BREAK_EN
      .BREAK_REQ  (breq),
`endif
      .TX_OUT     (tx[g]),
      .Busy       (busy[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: per instance, a queue holding the line value of every remaining busy cycle.
  bit mq[3][$];
  bit pend[3];

  task automatic push_frame(input int g, input logic [7:0] d, input bit p_en, input bit p_typ, input bit st2);
    bit bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (p_en) bits.push_back((^d) ^ p_typ);
    bits.push_back(1'b1);
    if (st2) bits.push_back(1'b1);
    foreach (bits[i])
      for (int k = 0; k < (1 << g); k++) mq[g].push_back(bits[i]);
  endtask

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int g = 0; g < 3; g++) begin
        mq[g].delete();
        pend[g] = 1'b0;
      end
    end else begin
      for (int g = 0; g < 3; g++) begin
        if (mq[g].size() != 0)
          void'(mq[g].pop_front());
        else if (dv) begin
          push_frame(g, pd, pe, pt, s2);
          if (breq) pend[g] = 1'b1;
        end else if (breq || pend[g]) begin
          for (int k = 0; k < 11 * (1 << g); k++) mq[g].push_back(1'b0);
          pend[g] = 1'b0;
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (RST) begin
      for (int g = 0; g < 3; g++) begin
        chk($sformatf("tx%0d", g), tx[g], (mq[g].size() != 0) ? mq[g][0] : 1'b1);
        chk($sformatf("busy%0d", g), busy[g], mq[g].size() != 0);
      end
    end
  end

  task automatic send(input logic [7:0] d, input bit p_en, input bit p_typ, input bit st2);
    @(negedge CLK);
    pd = d; pe = p_en; pt = p_typ; s2 = st2; dv = 1'b1;
    @(negedge CLK);
    dv = 1'b0;
    // Scramble config so a frame in flight must use its latched copy.
    pd = 8'($urandom); pe = 1'($urandom); pt = 1'($urandom); s2 = 1'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    idle(3);
    chk("rst_tx", tx, 3'b111);
    chk("rst_busy", busy, 3'b000);
    RST = 1'b1;
    idle(2);

    send(8'hA5, 1'b0, 1'b0, 1'b0); idle(60);
    send(8'h07, 1'b1, 1'b0, 1'b0); idle(60);
    send(8'h07, 1'b1, 1'b1, 1'b0); idle(60);
    send(8'hFF, 1'b0, 1'b0, 1'b1); idle(3);
    send(8'h12, 1'b0, 1'b0, 1'b0); idle(60);

    // Data_Valid held high across two words: one idle-high CLK between frames.
    @(negedge CLK);
    pd = 8'h55; pe = 1'b0; s2 = 1'b0; dv = 1'b1;
    @(negedge CLK);
    pd = 8'hAA;
    idle(30);
    dv = 1'b0;
    idle(60);

    // Mid-frame async reset aborts the frame at once.
    send(8'hC3, 1'b0, 1'b0, 1'b0);
    idle(3);
    @(posedge CLK);
    #2 RST = 1'b0;
    #1;
    chk("midrst_tx", tx, 3'b111);
    chk("midrst_busy", busy, 3'b000);
    @(negedge CLK);
    RST = 1'b1;
    send(8'h3C, 1'b0, 1'b0, 1'b0); idle(60);

`ifdef UART_TX_BREAK_EN
    @(negedge CLK); breq = 1'b1;
    @(negedge CLK); breq = 1'b0;
    idle(80);
    @(negedge CLK); pd = 8'h96; pe = 1'b1; pt = 1'b0; s2 = 1'b0; dv = 1'b1; breq = 1'b1;
    @(negedge CLK); dv = 1'b0; breq = 1'b0;
    idle(150);
`endif

    for (int c = 0; c < 3000; c++) begin
      @(negedge CLK);
      dv = ($urandom_range(0, 9) == 0);
      pd = 8'($urandom); pe = 1'($urandom); pt = 1'($urandom); s2 = 1'($urandom);
`ifdef UART_TX_BREAK_EN
      breq = ($urandom_range(0, 39) == 0);
`endif
    end
    dv = 1'b0; breq = 1'b0;
    idle(150);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
